// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter
//   Four-requester round-robin arbiter. The grant is registered and one-hot,
//   so it can drive encoder inputs in1..in4 directly.
//   Each release is followed by at least one IDLE cycle.
//
//   Optional feature: when the macro ARB_TIMEOUT_EN is defined, a grant that
//   is not released within HOLD_MAX cycles is forced off. The timeout output
//   pulses for the cycle after that forced release.
//
// Parameters
//   HOLD_MAX  maximum grant length in cycles when the timeout is compiled in
//             (legal range 2..255)
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   req1..req4      request lines
//   done            the current owner releases the grant
//   gnt1..gnt4      registered one-hot grant
//   busy            a grant is active
//   timeout         one-cycle pulse after a forced release (0 without macro)
module onehot_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req1,
    input  logic req2,
    input  logic req3,
    input  logic req4,
    input  logic done,
    output logic gnt1,
    output logic gnt2,
    output logic gnt3,
    output logic gnt4,
    output logic busy,
    output logic timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    logic [1:0] last;       // most recent winner, 0..3 for req1..req4
    logic [1:0] own;        // index of the current owner
    logic [1:0] pick;       // round-robin winner for the next grant
    logic [3:0] gnt;
    logic [3:0] reqv;
    logic       any_req;
    logic       rel;        // owner-initiated release: done or request drop
    logic       force_rel;  // hold limit reached

    assign reqv    = {req4, req3, req2, req1};
    assign any_req = |reqv;
    assign rel     = done | ~reqv[own];

    // Search order is last+1, last+2, last+3, last (2-bit wrap). The loop
    // runs from the lowest priority to the highest so that the final
    // assignment wins.
    always_comb begin
        pick = last;
        for (int unsigned i = 4; i >= 1; i--) begin
            if (reqv[last + 2'(i)]) begin
                pick = last + 2'(i);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold;       // GRANT cycles completed before the current one

    assign force_rel = (hold == 8'(HOLD_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hold    <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state == GRANT) begin
                if (rel || force_rel) begin
                    hold <= '0;
                end else begin
                    hold <= hold + 8'd1;
                end
                // A normal release on the same edge is not a timeout.
                if (!rel && force_rel) begin
                    timeout <= 1'b1;
                end
            end else begin
                hold <= '0;
            end
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            last  <= 2'd3;
            own   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= GRANT;
                        own   <= pick;
                        gnt   <= 4'b0001 << pick;
                        busy  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (rel || force_rel) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        last  <= own;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt1 = gnt[0];
    assign gnt2 = gnt[1];
    assign gnt3 = gnt[2];
    assign gnt4 = gnt[3];

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Testbench for onehot_rr_arbiter: directed scenarios plus a randomized run,
// with a per-cycle monitor comparing against a behavioural model.
module tb_onehot_rr_arbiter;

    localparam int unsigned HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req1 = 1'b0, req2 = 1'b0, req3 = 1'b0, req4 = 1'b0;
    logic done = 1'b0;
    logic gnt1, gnt2, gnt3, gnt4, busy, timeout;

    int total = 0;
    int bad   = 0;

    // behavioural model: owner index or -1, last winner, hold cycles, pulse
    int m_owner = -1;
    int m_last  = 3;
    int m_hold  = 0;
    bit m_to    = 1'b0;
    bit armed   = 1'b0;

    always #5 clk = ~clk;

    onehot_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req1    (req1),
        .req2    (req2),
        .req3    (req3),
        .req4    (req4),
        .done    (done),
        .gnt1    (gnt1),
        .gnt2    (gnt2),
        .gnt3    (gnt3),
        .gnt4    (gnt4),
        .busy    (busy),
        .timeout (timeout)
    );

    function automatic logic [3:0] gvec();
        return {gnt4, gnt3, gnt2, gnt1};
    endfunction

    task automatic set_req(input logic [3:0] r);
        {req4, req3, req2, req1} = r;
    endtask

    // One clock edge; the model advances with the inputs held across it.
    task automatic tick();
        bit rq[4];
        bit d;
        bit r;
        int c;
        bit rl;
        bit frc;
        rq = '{req1, req2, req3, req4};
        d  = done;
        r  = rst;
        @(posedge clk);
        if (r) begin
            m_owner = -1;
            m_last  = 3;
            m_hold  = 0;
            m_to    = 1'b0;
            armed   = 1'b1;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                c = (m_last + k) % 4;
                if (rq[c] && m_owner < 0) begin
                    m_owner = c;
                    m_hold  = 0;
                end
            end
        end else begin
            rl   = d || !rq[m_owner];
            frc  = TO_EN && !rl && (m_hold + 1 >= int'(HOLD));
            m_to = frc;
            if (rl || frc) begin
                m_last  = m_owner;
                m_owner = -1;
                m_hold  = 0;
            end else begin
                m_hold++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        done = 1'b0;
        set_req(4'b0000);
        tick();
        rst = 1'b0;
    endtask

    // Per-cycle monitor: model agreement, one-hot/zero, encoder codes.
    always @(negedge clk) begin
        logic [3:0] g;
        logic [3:0] e;
        logic [1:0] code;
        if (armed) begin
            g = gvec();
            e = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL mon_gnt t=%0t got=%b exp=%b", $time, g, e);
            end
            total++;
            if (busy !== (m_owner >= 0)) begin
                bad++;
                $display("FAIL mon_busy t=%0t got=%b exp=%b", $time, busy, (m_owner >= 0));
            end
            total++;
            if (timeout !== m_to) begin
                bad++;
                $display("FAIL mon_timeout t=%0t got=%b exp=%b", $time, timeout, m_to);
            end
            total++;
            if ($countones(g) > 1 || (busy === 1'b1 && g == 4'b0000)) begin
                bad++;
                $display("FAIL mon_onehot t=%0t got=%b busy=%b exp=onehot_or_zero", $time, g, busy);
            end
            if (m_owner >= 0) begin
                case (g)
                    4'b0001: code = 2'd0;
                    4'b0010: code = 2'd1;
                    4'b0100: code = 2'd2;
                    4'b1000: code = 2'd3;
                    default: code = 2'bxx;
                endcase
                total++;
                if (code !== 2'(m_owner)) begin
                    bad++;
                    $display("FAIL mon_encode t=%0t got=%b exp=%0d", $time, code, m_owner);
                end
            end
        end
    end

    task automatic test_reset();
        rst  = 1'b1;
        done = 1'b1;
        set_req(4'b1111);
        tick();
        tick();
        total++;
        if (gvec() !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset got gnt=%b busy=%b to=%b exp 0000/0/0", gvec(), busy, timeout);
        end
        rst  = 1'b0;
        done = 1'b0;
        set_req(4'b0000);
        tick();
    endtask

    task automatic test_rotation();
        int ord[5] = '{0, 1, 2, 3, 0};
        do_reset();
        set_req(4'b1111);
        tick();
        for (int k = 0; k < 5; k++) begin
            total++;
            if (gvec() !== (4'b0001 << ord[k]) || busy !== 1'b1) begin
                bad++;
                $display("FAIL rotation step=%0d got=%b exp=%b", k, gvec(), 4'b0001 << ord[k]);
            end
            if (k < 4) begin
                done = 1'b1;
                tick();
                total++;
                if (gvec() !== 4'b0000 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL rotation_gap step=%0d got=%b exp=0000", k, gvec());
                end
                done = 1'b0;
                tick();
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        set_req(4'b0100);
        tick();
        total++;
        if (gvec() !== 4'b0100) begin
            bad++;
            $display("FAIL hold_first got=%b exp=0100", gvec());
        end
        tick();
        tick();
        set_req(4'b0101);
        tick();
        total++;
        if (gvec() !== 4'b0100) begin
            bad++;
            $display("FAIL hold_ignore got=%b exp=0100", gvec());
        end
        set_req(4'b0001);
        tick();
        total++;
        if (gvec() !== 4'b0000) begin
            bad++;
            $display("FAIL hold_drop got=%b exp=0000", gvec());
        end
        tick();
        total++;
        if (gvec() !== 4'b0001) begin
            bad++;
            $display("FAIL hold_next got=%b exp=0001", gvec());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(4'b0010);
        tick();
        total++;
        if (gvec() !== 4'b0010) begin
            bad++;
            $display("FAIL midrst_pre got=%b exp=0010", gvec());
        end
        set_req(4'b1111);
        rst = 1'b1;
        tick();
        total++;
        if (gvec() !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst got=%b busy=%b exp=0000/0", gvec(), busy);
        end
        rst = 1'b0;
        tick();
        total++;
        if (gvec() !== 4'b0001) begin
            bad++;
            $display("FAIL midrst_after got=%b exp=0001", gvec());
        end
    endtask

    task automatic test_done_same_edge();
        do_reset();
        set_req(4'b0010);
        tick();
        tick();
        set_req(4'b1010);
        done = 1'b1;
        tick();
        total++;
        if (gvec() !== 4'b0000) begin
            bad++;
            $display("FAIL same_edge_gap got=%b exp=0000", gvec());
        end
        done = 1'b0;
        tick();
        total++;
        if (gvec() !== 4'b1000) begin
            bad++;
            $display("FAIL same_edge_next got=%b exp=1000", gvec());
        end
    endtask

    task automatic test_idle_done();
        do_reset();
        done = 1'b1;
        tick();
        total++;
        if (gvec() !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_done got=%b busy=%b exp=0000/0", gvec(), busy);
        end
        set_req(4'b0001);
        tick();
        total++;
        if (gvec() !== 4'b0001) begin
            bad++;
            $display("FAIL idle_done_grant got=%b exp=0001", gvec());
        end
        tick();
        total++;
        if (gvec() !== 4'b0000) begin
            bad++;
            $display("FAIL idle_done_release got=%b exp=0000", gvec());
        end
        done = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        set_req(4'b0001);
        tick();
        if (TO_EN) begin
            for (int i = 0; i < int'(HOLD); i++) begin
                total++;
                if (gvec() !== 4'b0001 || timeout !== 1'b0) begin
                    bad++;
                    $display("FAIL to_hold cyc=%0d got=%b to=%b exp=0001/0", i, gvec(), timeout);
                end
                if (i < int'(HOLD) - 1) tick();
            end
            tick();
            total++;
            if (gvec() !== 4'b0000 || timeout !== 1'b1) begin
                bad++;
                $display("FAIL to_force got=%b to=%b exp=0000/1", gvec(), timeout);
            end
            tick();
            total++;
            if (gvec() !== 4'b0001 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL to_regrant got=%b to=%b exp=0001/0", gvec(), timeout);
            end
        end else begin
            for (int i = 0; i < 110; i++) begin
                total++;
                if (gvec() !== 4'b0001 || timeout !== 1'b0) begin
                    bad++;
                    $display("FAIL no_to cyc=%0d got=%b to=%b exp=0001/0", i, gvec(), timeout);
                end
                tick();
            end
        end
        set_req(4'b0000);
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 3) == 0) set_req(4'($urandom_range(0, 15)));
            done = ($urandom_range(0, 7) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst  = 1'b0;
        done = 1'b0;
        set_req(4'b0000);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rotation();
        test_hold();
        test_reset_mid();
        test_done_same_edge();
        test_idle_done();
        test_timeout();
        test_random();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
